// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI-style SRAM slave backed by 2^ADDR_BITS 32-bit words.
//               Independent read and write FSMs; every burst is INCR with
//               4-byte beats, and the word index wraps modulo the depth.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   arid/araddr/arlen/arvalid/arready : read address channel
//   rid/rdata/rresp/rlast/rvalid/rready : read data channel
//   awid/awaddr/awlen/awvalid/awready : write address channel
//   wdata/wstrb/wlast/wvalid/wready   : write data channel
//   bid/bresp/bvalid/bready           : write response channel
//
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
   parameter int ADDR_BITS = 12
) (
   input  logic        clk,
   input  logic        rst,

   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic        arvalid,
   output logic        arready,

   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,

   input  logic [3:0]  awid,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic        awvalid,
   output logic        awready,

   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,

   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int DEPTH = 1 << ADDR_BITS;

   localparam logic [ADDR_BITS-1:0] IDX_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Read FSM encoding
   localparam logic [0:0] R_IDLE  = 1'b0;
   localparam logic [0:0] R_BURST = 1'b1;

   // Write FSM encoding
   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;

   // -------------------------------------------------------------------------
   // Storage (never reset: contents survive rst)
   // -------------------------------------------------------------------------
   logic [31:0] mem [DEPTH];

   // -------------------------------------------------------------------------
   // Read-side state
   // -------------------------------------------------------------------------
   logic [0:0]           r_state;
   logic [ADDR_BITS-1:0] rd_idx;   // index of the NEXT beat to load
   logic [7:0]           rd_cnt;   // number of the beat currently presented
   logic [7:0]           rd_len;

   // -------------------------------------------------------------------------
   // Write-side state
   // -------------------------------------------------------------------------
   logic [1:0]           w_state;
   logic [ADDR_BITS-1:0] wr_idx;
   logic [7:0]           wr_cnt;
   logic [7:0]           wr_len;
   logic                 wr_err;   // sticky wlast-mismatch flag for this burst

   // -------------------------------------------------------------------------
   // Decode
   // -------------------------------------------------------------------------
   logic [ADDR_BITS-1:0] ar_idx;
   logic [ADDR_BITS-1:0] aw_idx;
   logic                 w_fire;
   logic                 w_beat_last;
   logic                 w_beat_err;

   // Upper address bits alias, and the two byte-offset bits are ignored
   // because every beat is a full 4-byte word.
   assign ar_idx = araddr[ADDR_BITS+1:2];
   assign aw_idx = awaddr[ADDR_BITS+1:2];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{araddr[31:ADDR_BITS+2], araddr[1:0],
                               awaddr[31:ADDR_BITS+2], awaddr[1:0]};

   assign arready = (r_state == R_IDLE);
   assign rresp   = RESP_OKAY;

   assign awready = (w_state == W_IDLE);
   assign wready  = (w_state == W_DATA);
   assign bvalid  = (w_state == W_RESP);

   assign w_fire      = wvalid && wready;
   // The burst length comes from awlen; wlast is only cross-checked.
   assign w_beat_last = (wr_cnt == wr_len);
   assign w_beat_err  = (wlast != w_beat_last);

   // -------------------------------------------------------------------------
   // Byte-enabled memory write. Gated by rst so an aborted burst cannot
   // modify memory during the reset cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst && w_fire) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
               mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Read FSM. rdata is captured from the array with a non-blocking read, so
   // a write to the same word on the same edge returns the pre-write value.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= R_IDLE;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rid     <= 4'd0;
         rdata   <= 32'd0;
         rd_idx  <= '0;
         rd_cnt  <= 8'd0;
         rd_len  <= 8'd0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (arvalid) begin
                  rid     <= arid;
                  rd_len  <= arlen;
                  rdata   <= mem[ar_idx];
                  rd_idx  <= ar_idx + IDX_ONE;
                  rd_cnt  <= 8'd0;
                  rlast   <= (arlen == 8'd0);
                  rvalid  <= 1'b1;
                  r_state <= R_BURST;
               end
            end
            R_BURST: begin
               // rvalid is always 1 here; without rready everything holds.
               if (rready) begin
                  if (rlast) begin
                     rvalid  <= 1'b0;
                     rlast   <= 1'b0;
                     r_state <= R_IDLE;
                  end else begin
                     // Load the next beat on the acceptance edge: no bubble.
                     rdata  <= mem[rd_idx];
                     rd_idx <= rd_idx + IDX_ONE;
                     rd_cnt <= rd_cnt + 8'd1;
                     rlast  <= ((rd_cnt + 8'd1) == rd_len);
                  end
               end
            end
            default: begin
               r_state <= R_IDLE;
               rvalid  <= 1'b0;
               rlast   <= 1'b0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Write FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         w_state <= W_IDLE;
         bid     <= 4'd0;
         bresp   <= RESP_OKAY;
         wr_idx  <= '0;
         wr_cnt  <= 8'd0;
         wr_len  <= 8'd0;
         wr_err  <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (awvalid) begin
                  bid     <= awid;
                  wr_len  <= awlen;
                  wr_idx  <= aw_idx;
                  wr_cnt  <= 8'd0;
                  wr_err  <= 1'b0;
                  w_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (wvalid) begin
                  wr_idx <= wr_idx + IDX_ONE;
                  if (w_beat_last) begin
                     // A wlast mismatch flags SLVERR but the data still lands.
                     bresp   <= (wr_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     w_state <= W_RESP;
                  end else begin
                     wr_cnt <= wr_cnt + 8'd1;
                     wr_err <= wr_err || w_beat_err;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  w_state <= W_IDLE;
               end
            end
            default: begin
               w_state <= W_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_sram_slave
// Description : Scoreboard bench for axi_sram_slave. Stimulus pushes the
//               hand-computed expected R beats / B responses into queues; a
//               monitor pops and compares on every rvalid&&rready and
//               bvalid&&bready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

   localparam int AB = 12;

   logic        clk;
   logic        rst;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   axi_sram_slave #(.ADDR_BITS(AB)) dut (
      .clk(clk), .rst(rst),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Expected R beat: {rid, rdata, rlast, rresp}; expected B: {bid, bresp}
   logic [38:0] rq[$];
   logic [5:0]  bq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: handshake timeout got 0 want 1", name);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && rvalid && rready) begin
         total++;
         if (rq.size() == 0) begin
            bad++;
            $display("FAIL r_unexpected: got id=%0h data=%08h want no beat", rid, rdata);
         end else begin
            logic [38:0] e;
            e = rq.pop_front();
            if ({rid, rdata, rlast, rresp} !== e) begin
               bad++;
               $display("FAIL r_beat: got id=%0h data=%08h last=%0b resp=%0h want id=%0h data=%08h last=%0b resp=%0h",
                        rid, rdata, rlast, rresp, e[38:35], e[34:3], e[2], e[1:0]);
            end
         end
      end
      if (!rst && bvalid && bready) begin
         total++;
         if (bq.size() == 0) begin
            bad++;
            $display("FAIL b_unexpected: got id=%0h resp=%0h want no response", bid, bresp);
         end else begin
            logic [5:0] eb;
            eb = bq.pop_front();
            if ({bid, bresp} !== eb) begin
               bad++;
               $display("FAIL b_resp: got id=%0h resp=%0h want id=%0h resp=%0h",
                        bid, bresp, eb[5:2], eb[1:0]);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_r(input logic [3:0] id, input logic [31:0] d, input logic last);
      rq.push_back({id, d, last, 2'b00});
   endtask

   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [1:0] exp_resp);
      int n;
      n = 0;
      awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
      while (!awready && n < 50) begin tick(); n++; end
      if (!awready) timeout_fail("aw_wait");
      bq.push_back({id, exp_resp});
      tick();
      awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n;
      n = 0;
      wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
      while (!wready && n < 50) begin tick(); n++; end
      if (!wready) timeout_fail("w_wait");
      tick();
      wvalid = 1'b0;
   endtask

   task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      int n;
      n = 0;
      arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
      while (!arready && n < 50) begin tick(); n++; end
      if (!arready) timeout_fail("ar_wait");
      tick();
      arvalid = 1'b0;
      chk("ar_rvalid_t1", rvalid, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin tick(); n++; end
      chk("drain_pending", rq.size() + bq.size(), 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog: got timeout want completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1;
      arid = 0; araddr = 0; arlen = 0; arvalid = 0;
      awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
      wdata = 0; wstrb = 0; wlast = 0; wvalid = 0;
      rready = 1'b1; bready = 1'b1;
      repeat (3) tick();

      // Reset state (rst still high)
      chk("rst_arready", arready, 1);
      chk("rst_awready", awready, 1);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_ids", {rid, bid}, 0);
      chk("rst_resps", {rresp, bresp}, 0);
      chk("rst_rdata", rdata, 0);
      rst = 1'b0;
      tick();

      // Single write then read
      do_aw(4'd3, 32'h10, 8'd0, 2'b00);
      do_w(32'hDEADBEEF, 4'hF, 1'b1);
      drain();
      exp_r(4'd5, 32'hDEADBEEF, 1'b1);
      do_ar(4'd5, 32'h10, 8'd0);
      drain();

      // 4-beat burst, read back with beat 1 stalled two cycles
      do_aw(4'd1, 32'h40, 8'd3, 2'b00);
      do_w(32'd1, 4'hF, 1'b0);
      do_w(32'd2, 4'hF, 1'b0);
      do_w(32'd3, 4'hF, 1'b0);
      do_w(32'd4, 4'hF, 1'b1);
      drain();
      exp_r(4'd2, 32'd1, 1'b0);
      exp_r(4'd2, 32'd2, 1'b0);
      exp_r(4'd2, 32'd3, 1'b0);
      exp_r(4'd2, 32'd4, 1'b1);
      do_ar(4'd2, 32'h40, 8'd3);
      tick();                 // beat 0 accepted, beat 1 now presented
      rready = 1'b0;
      tick();
      tick();
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, 32'd2);
      chk("hold_rlast", rlast, 0);
      chk("hold_rid", rid, 4'd2);
      rready = 1'b1;
      drain();

      // Byte strobes
      do_aw(4'd4, 32'h20, 8'd0, 2'b00);
      do_w(32'h11223344, 4'hF, 1'b1);
      do_aw(4'd4, 32'h20, 8'd0, 2'b00);
      do_w(32'hAABBCCDD, 4'b0101, 1'b1);
      drain();
      exp_r(4'd6, 32'h11BB33DD, 1'b1);
      do_ar(4'd6, 32'h20, 8'd0);
      drain();

      // Wrap at top index with early wlast -> SLVERR, data still written
      do_aw(4'd7, 32'h3FFC, 8'd1, 2'b10);
      do_w(32'hA5A50001, 4'hF, 1'b1);
      do_w(32'hA5A50002, 4'hF, 1'b1);
      drain();
      exp_r(4'd8, 32'hA5A50001, 1'b0);
      exp_r(4'd8, 32'hA5A50002, 1'b1);
      do_ar(4'd8, 32'h3FFC, 8'd1);
      drain();
      exp_r(4'd9, 32'hA5A50002, 1'b1);
      do_ar(4'd9, 32'h0, 8'd0);
      drain();
      // Upper address bits alias onto the same word
      exp_r(4'd10, 32'hDEADBEEF, 1'b1);
      do_ar(4'd10, 32'h4010, 8'd0);
      drain();
      // Missing wlast on the final beat is also SLVERR
      do_aw(4'd11, 32'h30, 8'd0, 2'b10);
      do_w(32'h33, 4'hF, 1'b0);
      drain();

      // Concurrent AR and AW in the same cycle
      do_aw(4'd12, 32'h90, 8'd0, 2'b00);
      do_w(32'h77, 4'hF, 1'b1);
      drain();
      chk("both_ready", {arready, awready}, 2'b11);
      arid = 4'd14; araddr = 32'h90; arlen = 8'd0; arvalid = 1'b1;
      awid = 4'd13; awaddr = 32'h90; awlen = 8'd0; awvalid = 1'b1;
      exp_r(4'd14, 32'h77, 1'b1);
      bq.push_back({4'd13, 2'b00});
      tick();
      arvalid = 1'b0; awvalid = 1'b0;
      chk("conc_rvalid", rvalid, 1);
      chk("conc_wready", wready, 1);
      tick();                 // read beat consumed, write still waiting
      // Write beat and new AR on the same edge: read sees pre-write value
      chk("hazard_ready", {arready, wready}, 2'b11);
      arid = 4'd15; araddr = 32'h90; arlen = 8'd0; arvalid = 1'b1;
      wdata = 32'h99; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
      exp_r(4'd15, 32'h77, 1'b1);
      tick();
      arvalid = 1'b0; wvalid = 1'b0;
      drain();
      exp_r(4'd1, 32'h99, 1'b1);
      do_ar(4'd1, 32'h90, 8'd0);
      drain();

      // Reset in the middle of a read burst
      rready = 1'b0;
      do_ar(4'd3, 32'h40, 8'd3);
      tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_rvalid", rvalid, 0);
      chk("mid_rst_arready", arready, 1);
      chk("mid_rst_rdata", rdata, 0);
      rst = 1'b0;
      rready = 1'b1;
      tick();
      chk("post_rst_rvalid", rvalid, 0);
      exp_r(4'd4, 32'd1, 1'b0);
      exp_r(4'd4, 32'd2, 1'b0);
      exp_r(4'd4, 32'd3, 1'b0);
      exp_r(4'd4, 32'd4, 1'b1);
      do_ar(4'd4, 32'h40, 8'd3);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
